triangle_assembler: RTL and testbench

TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

---
 rtl/triangle_assembler_pkg.sv | 36 +++
 rtl/triangle_assembler_tri_fifo.sv | 55 +++++
 rtl/triangle_assembler.sv | 155 +++++++++++++++
 tb/tb_triangle_assembler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_assembler_pkg.sv
// Shared types for the triangle assembler: triangle record, issue-state enum,
// frame size default and the signed-area helper used by degenerate culling.
package triangle_assembler_pkg;

  localparam int TRIANGLES_DEFAULT = 72;
  localparam int VERTEX_W          = 20;
  localparam int COLOR_W           = 24;
  localparam int REC_W             = 3 * VERTEX_W + COLOR_W;

  typedef logic [VERTEX_W-1:0] vertex_t;  // {x[9:0], y[9:0]}

  typedef struct packed {
    vertex_t              a;
    vertex_t              b;
    vertex_t              c;
    logic [COLOR_W-1:0]   color;
  } tri_rec_t;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_ISSUE = 2'd1,
    ISSUE_BUSY  = 2'd2
  } issue_state_t;

  // Twice the signed area, deliberately kept at 22 bits (wraps like the hardware).
  function automatic logic signed [21:0] tri_area2(input vertex_t a, input vertex_t b,
                                                   input vertex_t c);
    logic signed [21:0] abx, aby, acx, acy;
    abx = $signed({12'd0, b[19:10]}) - $signed({12'd0, a[19:10]});
    aby = $signed({12'd0, b[9:0]})   - $signed({12'd0, a[9:0]});
    acx = $signed({12'd0, c[19:10]}) - $signed({12'd0, a[19:10]});
    acy = $signed({12'd0, c[9:0]})   - $signed({12'd0, a[9:0]});
    return abx * acy - aby * acx;
  endfunction

endpackage

// File: rtl/triangle_assembler_tri_fifo.sv
// Triangle record FIFO: register-array storage, head read straight from the
// array, push on a full FIFO is accepted only when a pop happens the same cycle.
module tri_fifo
  import triangle_assembler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  tri_rec_t               data_in,
  input  logic                   pop_in,
  output tri_rec_t               head_out,
  output logic                   empty_out,
  output logic                   drop_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int AW = $clog2(DEPTH);

  tri_rec_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full      = (count_out == (AW+1)'(DEPTH));
  assign empty_out = (count_out == '0);
  assign do_pop    = pop_in && !empty_out;
  assign do_push   = push_in && (!full || do_pop);
  assign drop_out  = push_in && !do_push;
  assign head_out  = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_out <= count_out + (AW+1)'(1);
        2'b01:   count_out <= count_out - (AW+1)'(1);
        default: count_out <= count_out;
      endcase
    end
  end

endmodule

// File: rtl/triangle_assembler.sv
// Groups screen vertices into triangles, buffers them and issues one at a time
// to the rasterizer. Define TRI_CULL_DEGENERATE_EN to drop zero-area triangles.
module triangle_assembler
  import triangle_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TRIANGLES  = TRIANGLES_DEFAULT
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        vertex_valid_in,
  input  logic [9:0]                  vertex_x_in,
  input  logic [9:0]                  vertex_y_in,
  input  logic [23:0]                 color_in,
  input  logic                        raster_last_in,
  output logic                        tri_valid_out,
  output logic [19:0]                 vertex_a_out,
  output logic [19:0]                 vertex_b_out,
  output logic [19:0]                 vertex_c_out,
  output logic [23:0]                 color_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
  output logic                        overflow_out,
  output logic                        frame_done_out,
  output issue_state_t                issue_state_out
);

  // Handshake: tri_valid_out is a one-cycle strobe with no ready; the next
  // triangle is held back until raster_last_in arrives while BUSY.

  localparam int RET_W = $clog2(TRIANGLES + 2) + 1;

  logic [1:0]       vtx_cnt;
  vertex_t          vtx_a;
  vertex_t          vtx_b;
  vertex_t          vtx_cur;
  logic             third_vtx;
  logic             culled;
  logic             push;
  logic             pop;
  logic             fifo_drop;
  logic             fifo_empty;
  logic             raster_done;
  tri_rec_t         rec_new;
  tri_rec_t         fifo_head;
  issue_state_t     state;
  logic [RET_W-1:0] retire_cnt;
  logic [RET_W-1:0] retire_sum;

  assign vtx_cur   = {vertex_x_in, vertex_y_in};
  assign third_vtx = vertex_valid_in && (vtx_cnt == 2'd2);
  assign rec_new   = '{a: vtx_a, b: vtx_b, c: vtx_cur, color: color_in};

`ifdef TRI_CULL_DEGENERATE_EN
  assign culled = third_vtx && (tri_area2(vtx_a, vtx_b, vtx_cur) == 22'sd0);
`else
  assign culled = 1'b0;
`endif

  assign push            = third_vtx && !culled;
  assign pop             = (state == ISSUE_IDLE) && !fifo_empty;
  assign raster_done     = (state == ISSUE_BUSY) && raster_last_in;
  assign issue_state_out = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vtx_cnt <= 2'd0;
      vtx_a   <= '0;
      vtx_b   <= '0;
    end else if (vertex_valid_in) begin
      case (vtx_cnt)
        2'd0: begin
          vtx_a   <= vtx_cur;
          vtx_cnt <= 2'd1;
        end
        2'd1: begin
          vtx_b   <= vtx_cur;
          vtx_cnt <= 2'd2;
        end
        default: vtx_cnt <= 2'd0;
      endcase
    end
  end

  tri_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push),
    .data_in   (rec_new),
    .pop_in    (pop),
    .head_out  (fifo_head),
    .empty_out (fifo_empty),
    .drop_out  (fifo_drop),
    .count_out (fifo_count_out)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ISSUE_IDLE;
      tri_valid_out <= 1'b0;
      vertex_a_out  <= '0;
      vertex_b_out  <= '0;
      vertex_c_out  <= '0;
      color_out     <= '0;
    end else begin
      case (state)
        ISSUE_IDLE: begin
          tri_valid_out <= 1'b0;
          if (!fifo_empty) begin
            state         <= ISSUE_ISSUE;
            tri_valid_out <= 1'b1;
            vertex_a_out  <= fifo_head.a;
            vertex_b_out  <= fifo_head.b;
            vertex_c_out  <= fifo_head.c;
            color_out     <= fifo_head.color;
          end
        end
        ISSUE_ISSUE: begin
          tri_valid_out <= 1'b0;
          state         <= ISSUE_BUSY;
        end
        ISSUE_BUSY: begin
          tri_valid_out <= 1'b0;
          if (raster_last_in) state <= ISSUE_IDLE;
        end
        default: begin
          tri_valid_out <= 1'b0;
          state         <= ISSUE_IDLE;
        end
      endcase
    end
  end

  // A rasterizer completion and a dropped record can land in the same cycle.
  assign retire_sum = retire_cnt + RET_W'(raster_done) + RET_W'(fifo_drop) + RET_W'(culled);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      retire_cnt     <= '0;
      frame_done_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      if (fifo_drop) overflow_out <= 1'b1;
      if (retire_sum >= RET_W'(TRIANGLES)) begin
        retire_cnt     <= retire_sum - RET_W'(TRIANGLES);
        frame_done_out <= 1'b1;
      end else begin
        retire_cnt     <= retire_sum;
        frame_done_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Self-checking bench for triangle_assembler: reset, issue latency, single
// outstanding triangle, overflow, culling, reset recovery and frame counting.
module tb_triangle_assembler;

  localparam int FIFO_DEPTH = 8;
  localparam int TRIANGLES  = 72;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        vertex_valid_in;
  logic [9:0]  vertex_x_in;
  logic [9:0]  vertex_y_in;
  logic [23:0] color_in;
  logic        raster_last_in;
  logic        tri_valid_out;
  logic [19:0] vertex_a_out;
  logic [19:0] vertex_b_out;
  logic [19:0] vertex_c_out;
  logic [23:0] color_out;
  logic [3:0]  fifo_count_out;
  logic        overflow_out;
  logic        frame_done_out;
  logic [1:0]  issue_state_out;

  logic [83:0] issued;
  logic [83:0] exp_q[$];
  int          checks       = 0;
  int          failures     = 0;
  int          issue_cnt    = 0;
  int          frame_pulses = 0;

  assign issued = {vertex_a_out, vertex_b_out, vertex_c_out, color_out};

  triangle_assembler #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TRIANGLES (TRIANGLES)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .vertex_valid_in (vertex_valid_in),
    .vertex_x_in     (vertex_x_in),
    .vertex_y_in     (vertex_y_in),
    .color_in        (color_in),
    .raster_last_in  (raster_last_in),
    .tri_valid_out   (tri_valid_out),
    .vertex_a_out    (vertex_a_out),
    .vertex_b_out    (vertex_b_out),
    .vertex_c_out    (vertex_c_out),
    .color_out       (color_out),
    .fifo_count_out  (fifo_count_out),
    .overflow_out    (overflow_out),
    .frame_done_out  (frame_done_out),
    .issue_state_out (issue_state_out)
  );

  // ---------------- clock / event counters ----------------
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (tri_valid_out === 1'b1) issue_cnt++;
    if (frame_done_out === 1'b1) frame_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst_in          = 1'b1;
    vertex_valid_in = 1'b0;
    vertex_x_in     = '0;
    vertex_y_in     = '0;
    color_in        = '0;
    raster_last_in  = 1'b0;
    repeat (2) step();
    rst_in = 1'b0;
    step();
    exp_q.delete();
  endtask

  task automatic drive_vertex(input logic [19:0] v, input logic [23:0] col);
    vertex_valid_in = 1'b1;
    vertex_x_in     = v[19:10];
    vertex_y_in     = v[9:0];
    color_in        = col;
    step();
    vertex_valid_in = 1'b0;
  endtask

  task automatic send_tri(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c,
                          input logic [23:0] col, input bit expect_push);
    if (expect_push) exp_q.push_back({a, b, c, col});
    drive_vertex(a, col);
    drive_vertex(b, col);
    drive_vertex(c, col);
  endtask

  task automatic pulse_raster();
    raster_last_in = 1'b1;
    step();
    raster_last_in = 1'b0;
  endtask

  task automatic wait_issue(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (tri_valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (tri_valid_out === 1'b1) seen = 1'b1;
  endtask

  function automatic logic [19:0] vtx(input int x, input int y);
    logic [9:0] xs;
    logic [9:0] ys;
    xs = 10'(x);
    ys = 10'(y);
    return {xs, ys};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    vertex_valid_in = 1'b0;
    raster_last_in  = 1'b0;
    #1;
    checks++;
    if (tri_valid_out !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", tri_valid_out);
    end
    checks++;
    if (issued !== 84'd0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", issued);
    end
    checks++;
    if (fifo_count_out !== 4'd0 || overflow_out !== 1'b0 || frame_done_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: count=%0d ovf=%b frame=%b want 0/0/0",
               fifo_count_out, overflow_out, frame_done_out);
    end
    checks++;
    if (issue_state_out !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d want 0", issue_state_out);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    logic [83:0] exp;
    apply_reset();
    send_tri(vtx(10, 10), vtx(50, 10), vtx(10, 40), 24'hFF0000, 1'b1);
    checks++;
    if (tri_valid_out !== 1'b0) begin
      failures++; $display("FAIL basic_early: got %b want 0 one cycle after third vertex", tri_valid_out);
    end
    step();
    checks++;
    if (tri_valid_out !== 1'b1) begin
      failures++; $display("FAIL basic_latency: got %b want 1 two cycles after third vertex", tri_valid_out);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
    checks++;
    if (issued !== exp || exp !== {20'h0280A, 20'h0C80A, 20'h02828, 24'hFF0000}) begin
      failures++; $display("FAIL basic_record: got %h want %h", issued, exp);
    end
    step();
    checks++;
    if (tri_valid_out !== 1'b0 || issue_state_out !== 2'd2) begin
      failures++; $display("FAIL basic_pulse: valid=%b state=%0d want 0/2", tri_valid_out, issue_state_out);
    end
    checks++;
    if (issued !== exp) begin
      failures++; $display("FAIL basic_stable: got %h want %h", issued, exp);
    end
    pulse_raster();
    checks++;
    if (issue_state_out !== 2'd0 || fifo_count_out !== 4'd0) begin
      failures++; $display("FAIL basic_idle: state=%0d count=%0d want 0/0", issue_state_out, fifo_count_out);
    end
  endtask

  task automatic test_one_outstanding();
    logic [83:0] exp;
    bit          seen;
    int          n0;
    apply_reset();
    send_tri(vtx(100, 100), vtx(200, 100), vtx(100, 300), 24'h00FF00, 1'b1);
    wait_issue(4, seen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
    checks++;
    if (!seen || issued !== exp) begin
      failures++; $display("FAIL outst_first: seen=%b got %h want %h", seen, issued, exp);
    end
    pulse_raster();  // sampled while in ISSUE, must be ignored
    n0 = issue_cnt;
    send_tri(vtx(1, 2), vtx(30, 2), vtx(1, 40), 24'h0000FF, 1'b1);
    repeat (5) step();
    checks++;
    if (issue_cnt != n0 || fifo_count_out !== 4'd1 || issue_state_out !== 2'd2) begin
      failures++;
      $display("FAIL outst_hold: issues=%0d count=%0d state=%0d want %0d/1/2",
               issue_cnt, fifo_count_out, issue_state_out, n0);
    end
    pulse_raster();
    wait_issue(4, seen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
    checks++;
    if (!seen || issued !== exp) begin
      failures++; $display("FAIL outst_second: seen=%b got %h want %h", seen, issued, exp);
    end
    step();
    pulse_raster();
  endtask

  task automatic test_overflow();
    logic [83:0] exp;
    bit          seen;
    int          n0;
    apply_reset();
    n0 = issue_cnt;
    for (int t = 0; t < 9; t++)
      send_tri(vtx(t, 1), vtx(t + 20, 1), vtx(t, 30), 24'(32'h100 + t), 1'b1);
    checks++;
    if (fifo_count_out !== 4'd8 || overflow_out !== 1'b0) begin
      failures++; $display("FAIL ovf_fill: count=%0d ovf=%b want 8/0", fifo_count_out, overflow_out);
    end
    send_tri(vtx(9, 1), vtx(29, 1), vtx(9, 30), 24'h000109, 1'b0);
    step();
    checks++;
    if (fifo_count_out !== 4'd8 || overflow_out !== 1'b1 || issue_cnt != n0 + 1) begin
      failures++;
      $display("FAIL ovf_drop: count=%0d ovf=%b issues=%0d want 8/1/%0d",
               fifo_count_out, overflow_out, issue_cnt, n0 + 1);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
    checks++;
    if (issued !== exp) begin
      failures++; $display("FAIL ovf_first: got %h want %h", issued, exp);
    end
    // Third vertex lands on the same edge as a pop from the full FIFO.
    drive_vertex(vtx(500, 500), 24'hABCDEF);
    drive_vertex(vtx(600, 500), 24'hABCDEF);
    pulse_raster();
    exp_q.push_back({vtx(500, 500), vtx(600, 500), vtx(500, 700), 24'hABCDEF});
    drive_vertex(vtx(500, 700), 24'hABCDEF);
    checks++;
    if (fifo_count_out !== 4'd8 || tri_valid_out !== 1'b1) begin
      failures++; $display("FAIL ovf_push_pop: count=%0d valid=%b want 8/1", fifo_count_out, tri_valid_out);
    end
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        step();
        pulse_raster();
        wait_issue(4, seen);
      end else begin
        seen = tri_valid_out;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
      checks++;
      if (!seen || issued !== exp) begin
        failures++; $display("FAIL ovf_drain%0d: seen=%b got %h want %h", k, seen, issued, exp);
      end
    end
    step();
    pulse_raster();
    checks++;
    if (fifo_count_out !== 4'd0 || overflow_out !== 1'b1) begin
      failures++; $display("FAIL ovf_end: count=%0d ovf=%b want 0/1", fifo_count_out, overflow_out);
    end
  endtask

  task automatic test_cull();
    logic [83:0] exp;
    bit          seen;
    int          n0;
    apply_reset();
    n0 = issue_cnt;
`ifdef TRI_CULL_DEGENERATE_EN
    send_tri(vtx(5, 5), vtx(10, 10), vtx(20, 20), 24'h123456, 1'b0);
    repeat (6) step();
    checks++;
    if (issue_cnt != n0 || fifo_count_out !== 4'd0 || overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL cull_drop: issues=%0d count=%0d ovf=%b want %0d/0/0",
               issue_cnt, fifo_count_out, overflow_out, n0);
    end
`else
    send_tri(vtx(5, 5), vtx(10, 10), vtx(20, 20), 24'h123456, 1'b1);
    wait_issue(4, seen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
    checks++;
    if (!seen || issued !== exp || issue_cnt != n0) begin
      failures++; $display("FAIL cull_issue: seen=%b got %h want %h", seen, issued, exp);
    end
    step();
    pulse_raster();
`endif
  endtask

  task automatic test_reset_mid();
    logic [83:0] exp;
    bit          seen;
    apply_reset();
    send_tri(vtx(7, 7), vtx(70, 7), vtx(7, 70), 24'h777777, 1'b1);
    wait_issue(4, seen);
    rst_in = 1'b1;
    #1;
    checks++;
    if (!seen || tri_valid_out !== 1'b0 || issue_state_out !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_async: seen=%b valid=%b state=%0d want 1/0/0", seen, tri_valid_out, issue_state_out);
    end
    apply_reset();
    drive_vertex(vtx(999, 999), 24'hDEAD00);
    drive_vertex(vtx(998, 1), 24'hDEAD00);
    apply_reset();
    send_tri(vtx(3, 4), vtx(40, 4), vtx(3, 60), 24'h00BEEF, 1'b1);
    wait_issue(4, seen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
    checks++;
    if (!seen || issued !== exp) begin
      failures++; $display("FAIL rstmid_new: seen=%b got %h want %h", seen, issued, exp);
    end
    step();
    pulse_raster();
  endtask

  task automatic test_frame();
    logic [83:0] exp;
    bit          seen;
    int          f0;
    int          x, y;
    apply_reset();
    f0 = frame_pulses;
    for (int t = 0; t < TRIANGLES; t++) begin
      x = $urandom_range(0, 900);
      y = $urandom_range(0, 900);
      send_tri(vtx(x, y), vtx(x + $urandom_range(1, 100), y),
               vtx(x, y + $urandom_range(1, 100)), 24'($urandom), 1'b1);
      wait_issue(4, seen);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 84'd0;
      checks++;
      if (!seen || issued !== exp) begin
        failures++; $display("FAIL frame_tri%0d: seen=%b got %h want %h", t, seen, issued, exp);
      end
      repeat (5) step();
      pulse_raster();
      checks++;
      if (frame_done_out !== (t == TRIANGLES - 1)) begin
        failures++; $display("FAIL frame_done%0d: got %b want %b", t, frame_done_out, t == TRIANGLES - 1);
      end
    end
    repeat (3) step();
    checks++;
    if (frame_pulses - f0 != 1) begin
      failures++; $display("FAIL frame_count: got %0d pulses want 1", frame_pulses - f0);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_one_outstanding();
    test_overflow();
    test_cull();
    test_reset_mid();
    test_frame();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_left: %0d entries not issued, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
